// File: rtl/smart_counter_ud.sv
// smart_counter_ud: modulo-MODULUS digit counter for the clock/timer datapath.
// Steps up automatically once every TICKS_PER_STEP tick pulses and emits a
// registered carry on the automatic wrap, so digits can be cascaded. It can
// also be adjusted up/down from two debounced buttons with hold-to-repeat, and
// supports a synchronous parallel load.
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   tick       timebase pulse (strobe or upstream carry)
//   en         enables automatic counting (buttons and load always work)
//   up_pos     press pulse of the up button
//   up_neg     release pulse of the up button
//   dn_pos     press pulse of the down button
//   dn_neg     release pulse of the down button
//   load       synchronous load strobe
//   load_val   value applied on load (out-of-range values load 0)
//   count      current value, registered
//   carry      one-cycle pulse on automatic wrap MODULUS-1 -> 0
//   repeating  high while the held button is auto-repeating
module smart_counter_ud #(
  parameter int unsigned MODULUS        = 60,
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned TICKS_PER_STEP = 100000000,
  parameter int unsigned HOLD_DELAY     = 300000000,
  parameter int unsigned REPEAT_PERIOD  = 50000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             en,
  input  logic             up_pos,
  input  logic             up_neg,
  input  logic             dn_pos,
  input  logic             dn_neg,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             carry,
  output logic             repeating
);

  localparam int unsigned HoldMax =
      (HOLD_DELAY > REPEAT_PERIOD) ? HOLD_DELAY : REPEAT_PERIOD;
  localparam int unsigned HoldW = (HoldMax > 1) ? $clog2(HoldMax) : 1;
  localparam int unsigned TickW = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;

  localparam logic [WIDTH-1:0] MaxVal   = WIDTH'(MODULUS - 1);
  localparam logic [TickW-1:0] TickLast = TickW'(TICKS_PER_STEP - 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_DELAY - 1);
  localparam logic [HoldW-1:0] RepLast  = HoldW'(REPEAT_PERIOD - 1);
  // One extra bit so MODULUS == 2^WIDTH is representable.
  localparam logic [WIDTH:0]   ModExt   = (WIDTH + 1)'(MODULUS);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StPress  = 2'd1;
  localparam logic [1:0] StRepeat = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             carry_q, carry_d;
  logic             rep_q, rep_d;
  logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
  logic             dir_q, dir_d;

  logic             btn_step;
  logic             release_evt;
  logic             tick_go;
  logic             auto_step;
  logic [WIDTH-1:0] up_val;
  logic [WIDTH-1:0] dn_val;
  logic [WIDTH-1:0] load_sat;

  assign up_val   = (count_q == MaxVal) ? '0 : count_q + WIDTH'(1);
  assign dn_val   = (count_q == '0) ? MaxVal : count_q - WIDTH'(1);
  assign load_sat = ({1'b0, load_val} < ModExt) ? load_val : '0;

  // Only the button that started the press can end it.
  assign release_evt = dir_q ? up_neg : dn_neg;

  assign tick_go   = (state_q == StIdle) && en && tick;
  assign auto_step = tick_go && (tick_cnt_q == TickLast);

  // Button FSM; its step request may be overridden below by load/auto step,
  // but the state transition happens regardless.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    dir_d      = dir_q;
    btn_step   = 1'b0;
    case (state_q)
      StIdle: begin
        if (up_pos && !dn_pos) begin
          btn_step   = 1'b1;
          dir_d      = 1'b1;
          hold_cnt_d = '0;
          state_d    = StPress;
        end else if (dn_pos && !up_pos) begin
          btn_step   = 1'b1;
          dir_d      = 1'b0;
          hold_cnt_d = '0;
          state_d    = StPress;
        end
      end
      StPress: begin
        if (release_evt) begin
          state_d = StIdle;
        end else if (hold_cnt_q == HoldLast) begin
          btn_step   = 1'b1;
          hold_cnt_d = '0;
          state_d    = StRepeat;
        end else begin
          hold_cnt_d = hold_cnt_q + HoldW'(1);
        end
      end
      StRepeat: begin
        if (release_evt) begin
          state_d = StIdle;
        end else if (hold_cnt_q == RepLast) begin
          btn_step   = 1'b1;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + HoldW'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Datapath with priority load > automatic step > button step.
  always_comb begin
    count_d    = count_q;
    carry_d    = 1'b0;
    tick_cnt_d = tick_cnt_q;

    if (tick_go) begin
      tick_cnt_d = auto_step ? '0 : tick_cnt_q + TickW'(1);
    end

    if (load) begin
      count_d    = load_sat;
      tick_cnt_d = '0;
    end else if (auto_step) begin
      count_d = up_val;
      carry_d = (count_q == MaxVal);
    end else if (btn_step) begin
      count_d = dir_d ? up_val : dn_val;
    end

    rep_d = (state_d == StRepeat);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      count_q    <= '0;
      carry_q    <= 1'b0;
      rep_q      <= 1'b0;
      tick_cnt_q <= '0;
      hold_cnt_q <= '0;
      dir_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      carry_q    <= carry_d;
      rep_q      <= rep_d;
      tick_cnt_q <= tick_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      dir_q      <= dir_d;
    end
  end

  assign count     = count_q;
  assign carry     = carry_q;
  assign repeating = rep_q;

endmodule

// File: doc/smart_counter_ud.md
# smart_counter_ud

Parametrised modulo-N digit counter for the clock/timer datapath: the successor to the single-button seconds/minutes/hours counter. It advances automatically on every TICKS_PER_STEP timebase pulses and emits a registered carry so digits can be cascaded. It is also adjustable up and down from two debounced buttons, with hold-to-repeat, and supports a synchronous parallel load. One instance per digit group (seconds, minutes, hours, alarm, timer).

## Interface
Parameters:
- MODULUS, 60: count range 0..MODULUS-1; MODULUS ≥ 2.
- WIDTH, 8: count width; MODULUS ≤ 2^WIDTH.
- TICKS_PER_STEP, 100000000: tick pulses per automatic increment; ≥ 1.
- HOLD_DELAY, 300000000: clk cycles a button must stay held before auto-repeat starts; ≥ 2.
- REPEAT_PERIOD, 50000000: clk cycles between auto-repeat steps; ≥ 1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- tick  in  1  timebase pulse; either a one-cycle strobe or an upstream carry.
- en  in  1  enables automatic counting; buttons and load work regardless.
- up_pos / up_neg  in  1  one-cycle press / release pulses of the debounced up button.
- dn_pos / dn_neg  in  1  one-cycle press / release pulses of the debounced down button.
- load  in  1  synchronous load strobe.
- load_val  in  WIDTH  value applied on load.
- count  out  WIDTH  current value, registered.
- carry  out  1  registered one-cycle pulse on automatic wrap MODULUS-1→0.
- repeating  out  1  high while in state REPEAT.

## Operation
- Step arithmetic, mod MODULUS:
  - Up: MODULUS-1→0, else +1.
  - Down: 0→MODULUS-1, else −1.
- Internal counters:
  - tick_cnt: 0..TICKS_PER_STEP-1.
  - hold_cnt: wide enough for max(HOLD_DELAY, REPEAT_PERIOD).
  - dir: 1 = up.
- Automatic step:
  - Condition: state == IDLE, en = 1, tick = 1, tick_cnt == TICKS_PER_STEP-1.
  - Effect: tick_cnt←0, up step. carry = 1 if and only if that step wraps to 0.
  - Otherwise tick = 1 with en = 1 in IDLE increments tick_cnt.
  - tick_cnt is frozen outside IDLE and while en = 0.
- FSM:
  - IDLE:
    - up_pos alone → up step, dir←1, hold_cnt←0, go PRESS.
    - dn_pos alone → down step, dir←0, hold_cnt←0, go PRESS.
    - up_pos and dn_pos together → ignored, stay IDLE.
  - PRESS:
    - Release of the active button (up_neg if dir = 1, else dn_neg) → IDLE, no step.
    - Else hold_cnt == HOLD_DELAY-1 → step in dir, hold_cnt←0, go REPEAT.
    - Else hold_cnt+1.
  - REPEAT:
    - Release of the active button → IDLE.
    - Else hold_cnt == REPEAT_PERIOD-1 → step in dir, hold_cnt←0.
    - Else hold_cnt+1.
  - Edges of the inactive button are ignored in PRESS and REPEAT.
  - Release pulses are ignored in IDLE.
- Priority within one cycle, highest first:
  - load: count←(load_val < MODULUS ? load_val : 0), tick_cnt←0, carry←0.
  - Automatic step.
  - Button or repeat step.
  - A suppressed button step is lost, but the FSM still takes its transition.
- Manual steps and loads never assert carry: adjustment does not ripple into the next digit.

## Timing
- Reset values: count = 0, carry = 0, repeating = 0, state IDLE, tick_cnt = 0, hold_cnt = 0, dir = 1.
- rst overrides all other inputs.
- Reset while a button is held: the block returns to IDLE; no repeat follows until a new press pulse arrives.
- Latency is 1 cycle: an input event in cycle T is visible on count, carry and repeating at T+1.
- carry is high for exactly the single cycle in which count first shows 0 after an automatic wrap.
- Press with up_pos in cycle T:
  - count changes at T+1.
  - First repeat step is visible at T+HOLD_DELAY+1.
  - Each further step follows every REPEAT_PERIOD cycles.
  - repeating rises at T+HOLD_DELAY+1.
- Release arriving in the same cycle as a hold or repeat threshold: release wins and no step occurs.
- Cascading: the carry of stage k drives tick of stage k+1 with TICKS_PER_STEP = 1. A full ripple adds one cycle per stage.

## Test plan
Parameters for all scenarios: MODULUS = 10, TICKS_PER_STEP = 4, HOLD_DELAY = 8, REPEAT_PERIOD = 3.
- Automatic wrap:
  - Stimulus: en = 1, tick every cycle from reset.
  - Required: count goes 0→1 after 4 ticks, reaches 9 after 36 ticks. On tick 40 count = 0 and carry is high for exactly 1 cycle. carry = 0 at every other time.
- Single presses:
  - Stimulus: dn_pos at count = 0, then dn_neg 2 cycles later. Next, up_pos at count = 9.
  - Required: count = 9 then 0; repeating stays 0; carry stays 0.
- Hold-repeat:
  - Stimulus: up_pos at T, up_neg at T+20, starting from count = 3.
  - Required: count = 4 at T+1, 5 at T+9, 6 at T+12, 7 at T+15, 8 at T+18. No further change. repeating is high from T+9 to T+20 inclusive.
- Simultaneous events:
  - Stimulus 1: up_pos with dn_pos in the same cycle. Required: no change.
  - Stimulus 2: up_pos in the same cycle as an automatic step at count = 5. Required: count = 6, state PRESS.
  - Stimulus 3: up_neg in the same cycle as the HOLD_DELAY threshold. Required: no step.
- Load:
  - Stimulus 1: load_val = 7. Required: count = 7, tick_cnt = 0.
  - Stimulus 2: load_val = 12. Required: count = 0.
  - Stimulus 3: load together with an automatic wrap. Required: count = load value, carry = 0.
- Reset mid-operation:
  - Stimulus: rst during REPEAT with the button still held, then tick activity with en = 0.
  - Required: all outputs return to reset values; no further steps occur.
